// File: rtl/spi_sink_pkg.sv
// Shared types and helpers for the SPI byte sink.
package spi_sink_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StTail
  } state_e;

  // Inserts one serial bit into the assembling byte in the configured bit order.
  function automatic logic [ByteW-1:0] shift_in(input logic [ByteW-1:0] sr, input logic b,
                                                 input bit msb_first);
    return msb_first ? {sr[ByteW-2:0], b} : {b, sr[ByteW-1:1]};
  endfunction

endpackage

// File: rtl/spi_sink_if.sv
// Serial input and byte-stream output bundle of the SPI sink.
interface spi_sink_if;
  import spi_sink_pkg::*;

  logic             sclk_i;
  logic             mosi_i;
  logic             cs_n_i;
  logic [ByteW-1:0] data_o;
  logic             valid_o;
  logic             ready_i;

  modport slave (
    input  sclk_i, mosi_i, cs_n_i, ready_i,
    output data_o, valid_o
  );

  modport master (
    output sclk_i, mosi_i, cs_n_i, ready_i,
    input  data_o, valid_o
  );

endinterface

// File: rtl/spi_sink_fifo.sv
// Byte buffer for the SPI sink: DEPTH-entry circular FIFO when SPI_SINK_FIFO_EN is defined,
// otherwise a single holding register.
module spi_sink_fifo
  import spi_sink_pkg::*;
`ifdef SPI_SINK_FIFO_EN
#(
  parameter int unsigned DEPTH = 4
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [ByteW-1:0] push_data,
  input  logic             pop,
  output logic [ByteW-1:0] data,
  output logic             valid,
  output logic             full
);

`ifdef SPI_SINK_FIFO_EN
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    fill_q;
  logic [ByteW-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign valid   = (fill_q != '0);
  assign full    = (fill_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push && (!full || do_pop);
  assign data    = valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end
`else
  logic [ByteW-1:0] data_q;
  logic             valid_q;
  logic             do_push, do_pop;

  assign valid   = valid_q;
  assign full    = valid_q;
  assign data    = data_q;
  assign do_pop  = pop && valid_q;
  assign do_push = push && (!valid_q || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (do_push) begin
      data_q  <= push_data;
      valid_q <= 1'b1;
    end else if (do_pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/spi_sink.sv
// SPI slave byte receiver: synchronises the serial pins, assembles bytes and buffers them.
// Buffer depth is DEPTH when SPI_SINK_FIFO_EN is defined, otherwise a single byte.
module spi_sink
  import spi_sink_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_sink_if.slave        bus,
  output logic [7:0]       count_o,
  output logic             ovf_o,
  output logic             frame_err_o,
  input  logic             clr_i,
  output logic             busy_o
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("spi_sink: DEPTH must be a power of two in 2..16");
  end

  logic [1:0] sclk_s_q, mosi_s_q, cs_s_q;
  logic       sclk_d_q, cs_d_q;
  logic       sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s_q <= 2'b00;
      mosi_s_q <= 2'b00;
      cs_s_q   <= 2'b11;
      sclk_d_q <= 1'b0;
      cs_d_q   <= 1'b1;
    end else begin
      sclk_s_q <= {sclk_s_q[0], bus.sclk_i};
      mosi_s_q <= {mosi_s_q[0], bus.mosi_i};
      cs_s_q   <= {cs_s_q[0], bus.cs_n_i};
      sclk_d_q <= sclk_s_q[1];
      cs_d_q   <= cs_s_q[1];
    end
  end

  assign sclk_rise = sclk_s_q[1] && !sclk_d_q;
  assign cs_fall   = cs_d_q && !cs_s_q[1];
  assign cs_rise   = !cs_d_q && cs_s_q[1];
  assign busy_o    = !cs_s_q[1];

  state_e           state_q, state_d;
  logic [ByteW-1:0] sr_q, sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             push, ferr_set;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = StShift;
      end
      StShift: begin
        if (cs_rise) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          ferr_set  = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          sr_d      = shift_in(sr_q, mosi_s_q[1], MSB_FIRST);
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StTail;
        end
      end
      StTail: begin
        push    = 1'b1;
        // A deselect seen here would otherwise be lost before returning to StShift.
        state_d = cs_rise ? StIdle : StShift;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  logic [ByteW-1:0] buf_data;
  logic             buf_valid, buf_full, pop;

  assign pop = buf_valid && bus.ready_i;

  spi_sink_fifo
`ifdef SPI_SINK_FIFO_EN
  #(
    .DEPTH (DEPTH)
  )
`endif
  u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (sr_q),
    .pop       (pop),
    .data      (buf_data),
    .valid     (buf_valid),
    .full      (buf_full)
  );

  assign bus.data_o  = buf_data;
  assign bus.valid_o = buf_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o     <= '0;
      ovf_o       <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (push) count_o <= count_o + 8'd1;
      if (clr_i) begin
        ovf_o       <= 1'b0;
        frame_err_o <= 1'b0;
      end else begin
        if (push && buf_full && !pop) ovf_o <= 1'b1;
        if (ferr_set)                 frame_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_sink.md
SPI_SINK -- requirements
Module: spi_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 4, byte buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1, bit order of the serial stream (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk_i  input  1  serial clock from processor SPI master, asynchronous to clk.
REQ-006 SHALL have port mosi_i  input  1  serial data from processor, sampled on sclk rising edge.
REQ-007 SHALL have port cs_n_i  input  1  chip select, active-low, frames a transfer.
REQ-008 SHALL have port data_o  output  8  head byte of buffer.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unread byte.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o & ready_i.
REQ-011 SHALL have port count_o  output  8  total bytes received, wraps 255->0.
REQ-012 SHALL have port ovf_o  output  1  sticky: byte dropped, buffer full.
REQ-013 SHALL have port frame_err_o  output  1  sticky: cs_n rose with 1..7 bits shifted.
REQ-014 SHALL have port clr_i  input  1  synchronous clear of ovf_o and frame_err_o.
REQ-015 SHALL have port busy_o  output  1  cs_n (synchronised) low.

Function
REQ-016 SHALL pass sclk_i, mosi_i, cs_n_i through two-flop synchronisers; one further sclk register forms the rising-edge detect.
REQ-017 SHALL keep FSM states IDLE, SHIFT, and TAIL: IDLE->SHIFT on synced cs_n falling; SHIFT->IDLE on synced cs_n rising; SHIFT->TAIL on eighth bit; TAIL->SHIFT next cycle.
REQ-018 SHALL, in SHIFT only, shift the synced mosi into an 8-bit shift register and increment a 3-bit bit counter on each detected sclk rise; edges in IDLE are ignored.
REQ-019 SHALL, in TAIL, push the assembled byte into the buffer and increment count_o, so valid_o rises 4 clk cycles after the raw eighth sclk rise into an empty buffer.
REQ-020 SHALL, on a push into a full buffer, drop the new byte, keep buffer contents, set ovf_o, and still increment count_o.
REQ-021 SHALL pop on valid_o & ready_i; a simultaneous push and pop on a full buffer SHALL succeed without setting ovf_o.
REQ-022 SHALL, on cs_n rising with bit counter 1..7, discard the partial byte, clear the bit counter, and set frame_err_o; with counter 0 no error.
REQ-023 SHALL let clr_i win over a same-cycle flag set (flags read 0 next cycle).
REQ-024 SHALL require sclk high and low phases of at least 3 clk cycles; faster sclk is undefined.
REQ-025 SHALL hold data_o stable while valid_o & !ready_i.

Reset
REQ-026 SHALL, on rst_n low, immediately clear FSM to IDLE, buffer empty, valid_o=0, data_o=0, count_o=0, ovf_o=0, frame_err_o=0, busy_o=0, and set synchronisers to sclk=0, cs_n=1.
REQ-027 SHALL discard any partial byte when reset occurs mid-transfer; the first byte after release SHALL require a fresh cs_n falling edge.

Configuration
REQ-028 SHALL use macro SPI_SINK_FIFO_EN: defined, a DEPTH-entry circular FIFO with wrapping read/write pointers; undefined, a single byte holding register (effective depth 1) and DEPTH ignored.

Structure
REQ-029 SHALL place the state enum (IDLE, SHIFT, TAIL) and the byte-width constant in shared package spi_sink_pkg.
REQ-030 SHALL instantiate sub-module spi_sink_fifo for buffering (the single-register variant when SPI_SINK_FIFO_EN is undefined).

Verification
REQ-031 SHALL cover: cs_n low, send 0xA5 MSB first, sclk period 8 clk -> valid_o, data_o=0xA5, count_o=1.
REQ-032 SHALL cover: ready_i=0, SPI_SINK_FIFO_EN defined, DEPTH=4, send 5 bytes 0x01..0x05 -> ovf_o=1, pops yield 0x01..0x04, count_o=5.
REQ-033 SHALL cover: send 3 bits then raise cs_n -> frame_err_o=1, valid_o=0; then full byte 0x3C -> data_o=0x3C.
REQ-034 SHALL cover: ovf_o=1, clr_i pulsed in the same cycle as a new overflow -> ovf_o=0 next cycle.
REQ-035 SHALL cover: rst_n low after 5 bits of 0xFF -> all outputs 0; new frame 0x81 -> data_o=0x81, count_o=1.
REQ-036 SHALL cover: count_o at 255, receive one byte -> count_o=0.
